// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Reset-and-lock supervisor for the audio PLL, running on the 50 MHz
// reference clock. It pulses the PLL reset, waits for lock, retries the PLL
// when lock does not arrive in time, and only releases the audio-domain reset
// once lock has been continuously present for a qualification window.
// Loss-of-lock and lock-timeout events are counted (saturating) so the HPS
// can read them back.
//
// Parameters:
//   RST_CYCLES     cycles pll_rst is held high per PLL reset pulse (>= 2)
//   LOCK_TIMEOUT   cycles allowed in WAIT_LOCK before retrying the PLL
//   STABLE_CYCLES  consecutive synchronized-locked cycles before release
//   CNT_W          width of the event counters
//
// Ports:
//   clk              in   50 MHz reference clock
//   reset_n          in   asynchronous active-low reset
//   locked           in   PLL lock indicator, asynchronous to clk
//   cnt_clr          in   synchronous pulse clearing both event counters
//   pll_rst          out  active-high reset to the PLL
//   sys_reset_n      out  active-low reset for the audio datapath
//   lock_ok          out  high only in RUN
//   state            out  0 RESET_PLL, 1 WAIT_LOCK, 2 QUALIFY, 3 RUN
//   lock_lost_count  out  RUN -> RESET_PLL transitions, saturating
//   timeout_count    out  WAIT_LOCK timeouts, saturating
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             locked,
   input  logic             cnt_clr,
   output logic             pll_rst,
   output logic             sys_reset_n,
   output logic             lock_ok,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] lock_lost_count,
   output logic [CNT_W-1:0] timeout_count
);

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      QUALIFY   = 2'd2,
      RUN       = 2'd3
   } state_t;

   // The single cycle counter has to reach the largest of the three windows.
   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CYC_W   = $clog2(MAX_CYC + 1);

   localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_CYCLES - 1);
   localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
   localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);
   localparam logic [CYC_W-1:0] CYC_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           cur_state;
   state_t           nxt_state;
   logic [CYC_W-1:0] cyc_cnt;
   logic             locked_meta;
   logic             locked_s;
   logic             timeout_inc;
   logic             lost_inc;

   // Two-flop synchronizer for the asynchronous PLL lock flag. Everything
   // downstream looks only at locked_s, never at the raw input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         locked_meta <= 1'b0;
         locked_s    <= 1'b0;
      end else begin
         locked_meta <= locked;
         locked_s    <= locked_meta;
      end
   end

   // State register plus the shared cycle counter. The counter restarts at
   // zero whenever the state changes, so in every state it reads the number
   // of cycles already spent there. It holds at its top value in RUN rather
   // than wrapping, which keeps it meaningless but harmless there.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_state <= RESET_PLL;
         cyc_cnt   <= '0;
      end else begin
         cur_state <= nxt_state;
         if (nxt_state != cur_state) begin
            cyc_cnt <= '0;
         end else if (cyc_cnt != CYC_MAX) begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
         end
      end
   end

   // Next-state logic. A drop of locked_s in QUALIFY wins over the window
   // completing, so any low sample restarts qualification from WAIT_LOCK.
   always_comb begin
      nxt_state   = cur_state;
      timeout_inc = 1'b0;
      lost_inc    = 1'b0;
      case (cur_state)
         RESET_PLL: begin
            if (cyc_cnt == RST_LAST) begin
               nxt_state = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               nxt_state = QUALIFY;
            end else if (cyc_cnt == TIMEOUT_LAST) begin
               nxt_state   = RESET_PLL;
               timeout_inc = 1'b1;
            end
         end
         QUALIFY: begin
            if (!locked_s) begin
               nxt_state = WAIT_LOCK;
            end else if (cyc_cnt == STABLE_LAST) begin
               nxt_state = RUN;
            end
         end
         RUN: begin
            if (!locked_s) begin
               nxt_state = RESET_PLL;
               lost_inc  = 1'b1;
            end
         end
         default: begin
            nxt_state = RESET_PLL;
         end
      endcase
   end

   // Saturating event counters. A clear in the same cycle as an event leaves
   // the counter at one: the clear is applied first, then the increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_count   <= '0;
         lock_lost_count <= '0;
      end else begin
         if (cnt_clr) begin
            timeout_count <= timeout_inc ? CNT_W'(1) : '0;
         end else if (timeout_inc && (timeout_count != CNT_MAX)) begin
            timeout_count <= timeout_count + CNT_W'(1);
         end
         if (cnt_clr) begin
            lock_lost_count <= lost_inc ? CNT_W'(1) : '0;
         end else if (lost_inc && (lock_lost_count != CNT_MAX)) begin
            lock_lost_count <= lock_lost_count + CNT_W'(1);
         end
      end
   end

   // Outputs are pure decodes of the state register, so nothing reaches an
   // output combinationally from an input, and the reset values appear the
   // moment reset_n asserts.
   assign pll_rst     = (cur_state == RESET_PLL);
   assign sys_reset_n = (cur_state == RUN);
   assign lock_ok     = (cur_state == RUN);
   assign state       = cur_state;

endmodule
